arb_mux_n_1: RTL

ARB_MUX_N_1 -- requirements
Module: arb_mux_n_1

---
 rtl/arb_mux_pkg.sv | 18 +
 rtl/arb_mux_arbiter.sv | 47 ++++
 rtl/arb_mux_n_1.sv | 129 ++++++++++++
 3 files changed

// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the N:1 arbitrated mux.
// Latency: none (package only).
// Backpressure: n/a.
package arb_mux_pkg;

    // Legal range for the number of input channels.
    localparam int N_CH_MIN = 1;
    localparam int N_CH_MAX = 16;

    // Width of a channel index; at least one bit so a single-channel
    // build still has a well-formed out_sel port.
    function automatic int sel_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/arb_mux_arbiter.sv
// Grant generator: picks the first requesting channel at or after ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none here; the top level qualifies the grant with can_load.
//
// Ports:
//   req_i      per-channel request (the in_valid vector)
//   ptr_i      search start index; tie to 0 for fixed lowest-index priority
//   gnt_o      one-hot grant, all zeros when nothing requests
//   gnt_idx_o  binary index of the granted channel (0 when no grant)
module arb_mux_arbiter
    import arb_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = sel_w(N_CH)
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [N_CH-1:0]  gnt_o,
    output logic [SEL_W-1:0] gnt_idx_o
);

    logic found;

    // Two ascending passes: first over channels ptr..N_CH-1, then over
    // 0..N_CH-1 to cover the wrapped part. The first hit wins, which gives
    // the search order ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && req_i[i] && (i >= int'(ptr_i))) begin
                found     = 1'b1;
                gnt_o[i]  = 1'b1;
                gnt_idx_o = SEL_W'(i);
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!found && req_i[i]) begin
                found     = 1'b1;
                gnt_o[i]  = 1'b1;
                gnt_idx_o = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/arb_mux_n_1.sv
// N:1 arbitrated mux into a single registered output slot.
// Latency: 1 cycle from input handshake to out_valid.
// Backpressure: in_ready drops when the output slot is full and not draining;
//               drain and load can overlap, so throughput is 1 word per cycle.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_data/in_ready per-channel inputs; channel i data at [i*W +: W]
//   out_valid/out_data/out_sel registered output word and its source channel
//   out_ready                 downstream accept
//
// Build option: define ARB_MUX_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority (lowest index wins) and no pointer register exists.
module arb_mux_n_1
    import arb_mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int W     = 4,
    localparam int SEL_W = sel_w(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_sel,
    input  logic              out_ready
);

    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_n_ch
        $error("arb_mux_n_1: N_CH out of range");
    end

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;

    logic [SEL_W-1:0] ptr;
    logic [N_CH-1:0]  gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic [W-1:0]     gnt_dat;
    logic             can_load;
    logic             load;

    arb_mux_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arbiter (
        .req_i     (in_valid),
        .ptr_i     (ptr),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // The slot can accept when empty or when its word leaves this cycle.
    // Reset masks every ready so nothing is accepted while it is held.
    assign can_load = !out_valid_q || out_ready;
    assign in_ready = gnt & in_valid & {N_CH{can_load && !rst}};
    assign load     = |in_ready;

    // Grant is one-hot, so an OR-of-ANDs mux selects the winner's data.
    always_comb begin
        gnt_dat = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt[i]) begin
                gnt_dat = in_data[i*W +: W];
            end
        end
    end

    // Data and source index only change on a load, so a drained word stays
    // visible on out_data/out_sel after out_valid falls.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_dat;
            out_sel_d   = gnt_idx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

`ifdef ARB_MUX_ROUND_ROBIN_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;

    // After serving channel g, the search starts just past it next time.
    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    // Search always starts at channel 0: lowest index wins.
    assign ptr = '0;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
